// File: rtl/sdf_r2_stage_if.sv
// Streaming port bundle for one radix-2 SDF FFT stage: sample in, result out,
// and the combinational twiddle ROM lookup.
interface sdf_r2_stage_if #(
  parameter int W     = 8,
  parameter int LOG2D = 2
);
  localparam int TAW = (LOG2D > 0) ? LOG2D : 1;

  logic             in_valid;
  logic [2*W-1:0]   in_data;
  logic [TAW-1:0]   tw_addr;
  logic [2*W-1:0]   tw_data;
  logic             out_valid;
  logic [2*W-1:0]   out_data;
  logic             out_sop;

  modport master (
    output in_valid, in_data, tw_data,
    input  tw_addr, out_valid, out_data, out_sop
  );

  modport slave (
    input  in_valid, in_data, tw_data,
    output tw_addr, out_valid, out_data, out_sop
  );
endinterface

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback DIF FFT stage, generic in width and delay depth.
// Optional build macro SDF_ROUND_EN: round-half-up in the twiddle multiplier instead of floor.
module sdf_r2_stage #(
  parameter int W     = 8,
  parameter int LOG2D = 2
) (
  input  logic           clk,
  input  logic           clear,
  sdf_r2_stage_if.slave  bus
);
  localparam int D = 1 << LOG2D;

  logic [LOG2D:0]   cnt;
  logic             primed;
  logic [2*W-1:0]   dline [D];
  logic [2*W-1:0]   tap;
  logic             phase_b;
  logic             cnt_lo_zero;

  assign tap     = dline[D-1];
  assign phase_b = cnt[LOG2D];

  generate
    if (LOG2D > 0) begin : g_addr
      assign bus.tw_addr = cnt[LOG2D-1:0];
      assign cnt_lo_zero = (cnt[LOG2D-1:0] == '0);
    end else begin : g_addr_2pt
      assign bus.tw_addr = 1'b0;
      assign cnt_lo_zero = 1'b1;
    end
  endgenerate

  // Butterfly at W+1 bits; dropping the LSB of the sign-extended sum is a floor shift.
  logic [W-1:0] tap_re, tap_im, x_re, x_im;
  logic [W-1:0] s_re, s_im, d_re, d_im;

  assign tap_re = tap[2*W-1:W];
  assign tap_im = tap[W-1:0];
  assign x_re   = bus.in_data[2*W-1:W];
  assign x_im   = bus.in_data[W-1:0];

  assign s_re = W'(({tap_re[W-1], tap_re} + {x_re[W-1], x_re}) >> 1);
  assign s_im = W'(({tap_im[W-1], tap_im} + {x_im[W-1], x_im}) >> 1);
  assign d_re = W'(({tap_re[W-1], tap_re} - {x_re[W-1], x_re}) >> 1);
  assign d_im = W'(({tap_im[W-1], tap_im} - {x_im[W-1], x_im}) >> 1);

  // Complex multiply of the delayed difference by the twiddle, Q1.(W-1).
  logic signed [2*W:0] ar, ai, br, bi;
  logic signed [2*W:0] prod_re, prod_im, acc_re, acc_im, shr_re, shr_im;
  logic [2*W-1:0]      mul_q;

  assign ar = {{(W+1){tap_re[W-1]}}, tap_re};
  assign ai = {{(W+1){tap_im[W-1]}}, tap_im};
  assign br = {{(W+1){bus.tw_data[2*W-1]}}, bus.tw_data[2*W-1:W]};
  assign bi = {{(W+1){bus.tw_data[W-1]}}, bus.tw_data[W-1:0]};

  assign prod_re = ar * br - ai * bi;
  assign prod_im = ar * bi + ai * br;

`ifdef SDF_ROUND_EN
  localparam logic signed [2*W:0] RND = {{(W+2){1'b0}}, 1'b1, {(W-2){1'b0}}};
  assign acc_re = prod_re + RND;
  assign acc_im = prod_im + RND;
`else
  assign acc_re = prod_re;
  assign acc_im = prod_im;
`endif

  assign shr_re = acc_re >>> (W-1);
  assign shr_im = acc_im >>> (W-1);

  function automatic logic [W-1:0] sat(input logic signed [2*W:0] v);
    logic [W-1:0] r;
    if (!v[2*W] && (|v[2*W-1:W-1]))
      r = {1'b0, {(W-1){1'b1}}};
    else if (v[2*W] && !(&v[2*W-1:W-1]))
      r = {1'b1, {(W-1){1'b0}}};
    else
      r = v[W-1:0];
    return r;
  endfunction

  assign mul_q = {sat(shr_re), sat(shr_im)};

  // Phase A stores the new sample and emits the previous frame's twiddled difference;
  // phase B emits the half-sum and feeds back the half-difference.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt           <= '0;
      primed        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sop   <= 1'b0;
      for (int i = 0; i < D; i++) dline[i] <= '0;
    end else begin
      bus.out_valid <= bus.in_valid & (phase_b | primed);
      bus.out_sop   <= bus.in_valid & phase_b & cnt_lo_zero;
      if (bus.in_valid) begin
        cnt      <= cnt + (LOG2D+1)'(1);
        dline[0] <= phase_b ? {d_re, d_im} : bus.in_data;
        for (int i = 1; i < D; i++) dline[i] <= dline[i-1];
        if (phase_b) primed <= 1'b1;
        if (phase_b || primed)
          bus.out_data <= phase_b ? {s_re, s_im} : mul_q;
      end
    end
  end
endmodule

// File: doc/sdf_r2_stage.md
# sdf_r2_stage

Parametrised radix-2 single-path delay-feedback (SDF) decimation-in-frequency FFT stage with an internal sample counter, a valid-qualified data path and per-stage scaling. It replaces the hand-wired demux/delay/butterfly/multiply/quantize chain with one stage generic in component width and delay depth. Stages are cascaded with LOG2D = S-1 … 0 to build a 2^S-point pipeline FFT. An external twiddle ROM is addressed by the stage and answers combinationally.

## Interface
- W, 8, width of each real/imaginary component, signed two's complement
- LOG2D, 2, log2 of delay-line depth D; stage butterflies span 2D points (LOG2D ≥ 0)
- clk  in  1  single clock, all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- in_valid  in  1  in_data carries a sample this cycle
- in_data  in  2W  complex sample {re[2W-1:W], im[W-1:0]}
- tw_addr  out  max(LOG2D,1)  twiddle index m (combinational from counter)
- tw_data  in  2W  twiddle W^m = exp(-j·2πm/2D), Q1.(W-1), {re, im}, valid same cycle as tw_addr
- out_valid  out  1  out_data valid this cycle
- out_data  out  2W  complex result {re, im}
- out_sop  out  1  marks first output of each frame's sum half

## Operation
- Counter cnt, LOG2D+1 bits, increments only on in_valid, wraps 2D-1 → 0. Phase A: cnt[LOG2D]=0; phase B: cnt[LOG2D]=1.
- Delay line: D complex words, shifts only on in_valid; tap = oldest word.
- Phase A, per valid input: push in_data into delay line; result = Q(tap × tw_data), tw_addr = cnt[LOG2D-1:0] (0 when LOG2D=0).
- Phase B, per valid input: s = (tap + in_data) >>> 1, d = (tap − in_data) >>> 1, computed at W+1 bits, arithmetic shift (floor), result W bits per component; result = s; push d.
- Complex multiply: re = ar·br − ai·bi, im = ar·bi + ai·br at 2W+1 bits; Q = shift right W-1 (truncate, or round per Configuration), then saturate to [−2^(W-1), 2^(W-1)−1].
- primed flag: 0 after clear; set on first phase-B valid input. Output during phase A is suppressed until primed (delay line holds zeros, not data).
- Output order per frame x[0..2D-1]: (x[n]+x[n+D])/2 for n=0..D-1, then, during the next frame's phase A, ((x[m]−x[m+D])/2)·W^m for m=0..D-1.
- Flush: last frame's difference half is emitted only as D further valid inputs (any value, typically zero) are applied.
- out_sop = 1 with the output of the cnt=D input.

## Timing
- Reset (clear=1 at an edge): cnt=0, primed=0, delay line all zero, out_valid=0, out_data=0, out_sop=0. clear overrides a simultaneous in_valid; that sample is discarded.
- Clear mid-frame: partial frame abandoned; next valid input is x[0] of a new frame.
- Latency: 1 cycle, in_valid at edge t → out_valid/out_data/out_sop registered at edge t+1.
- out_valid = registered (in_valid & (phase B | primed)).
- in_valid=0: cnt, delay line, primed hold; out_valid=0 next cycle; out_data holds last value.
- Back-to-back valid inputs supported every cycle; no backpressure.
- tw_addr is combinational from cnt; tw_data must settle within the same cycle.

## Configuration
- SDF_ROUND_EN defined: multiplier adds 2^(W-2) before the W-1 right shift (round half up), then saturates.
- Not defined: plain truncation (floor) before saturation. Butterfly >>>1 is always floor in both builds.

## Test plan
- W=8, LOG2D=2, impulse: frame x0={0x40,0x00}, x1..x7=0, then 4 zero flush samples, tw={0x7F,0x00} for m=0 → outputs {0x20,0},0,0,0 (sop on first), then {0x1F,0x00} without SDF_ROUND_EN, {0x20,0x00} with it, then 0,0,0.
- Saturation: x0={0x80,0}, x4={0x7F,0} → d={0x80,0}; tw={0x80,0} at m=0 → phase-A output {0x7F,0x00} (128 saturated).
- Stall: same impulse frame with in_valid toggled 1,0,1,0… → identical output sequence; out_valid high only on cycles following valid inputs; cnt unchanged on idle cycles.
- Clear mid-frame: 5 valid samples, clear=1 with in_valid=1 → all outputs 0 next cycle; following 8-sample frame yields the same results as from power-up, no emission before the first phase B.
- LOG2D=0 (2-point): inputs a={0x10,0x08}, b={0x04,0x02}, tw={0x7F,0} → {0x0A,0x05} then {0x05,0x02} (truncated) on next valid input.
- Continuous random frames, W=8 and W=12, LOG2D=3 → bit-exact match to reference model including floor/round and saturation.
